// File: rtl/ecc_pkg.sv
// Shared defaults and requester-id encoding for the ECC encoder arbiter.
package ecc_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned CHK_W_DEF  = 8;
    localparam int unsigned LAT_DEF    = 2;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/ecc_rr_arb2.sv
// Two-way round-robin arbiter. The pointer holds the last granted requester
// and moves only when the caller signals that the granted word was taken.
module ecc_rr_arb2
    import ecc_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    valid0,
    input  logic    valid1,
    input  logic    update,
    output logic    gnt_valid,
    output req_id_t gnt_id
);

    req_id_t last;

    // Grant the lone requester, or on a tie the one not granted last.
    always_comb begin
        gnt_valid = valid0 | valid1;
        gnt_id    = REQ0;
        if (valid0 && valid1) begin
            gnt_id = (last == REQ0) ? REQ1 : REQ0;
        end else if (valid1) begin
            gnt_id = REQ1;
        end
    end

    // Pointer starts at REQ1 so that req0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= REQ1;
        end else if (update && gnt_valid) begin
            last <= gnt_id;
        end
    end

endmodule

// File: rtl/ecc_enc_arb.sv
// Arbitrates two requesters onto one external pipelined ECC encoder and
// tracks which requester owns each word with a shadow valid/id pipeline.
module ecc_enc_arb
    import ecc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CHK_W  = CHK_W_DEF,
    parameter int unsigned LAT    = LAT_DEF
) (
    input  logic              ecc_clk,
    input  logic              ecc_reset_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              enc_reset,
    output logic              enc_clken,
    output logic [DATA_W-1:0] enc_data_in,
    input  logic [DATA_W-1:0] enc_data_out,
    input  logic [CHK_W-1:0]  enc_chkbits_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_chk,
    output logic              out_id,
    output logic [15:0]       word_cnt
);

    logic    adv;
    logic    fire;
    logic    gnt_valid;
    req_id_t gnt_id;
    logic    stage_valid [LAT];
    req_id_t stage_id    [LAT];

    ecc_rr_arb2 u_arb (
        .clk       (ecc_clk),
        .rst_n     (ecc_reset_n),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .update    (adv),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign out_valid = stage_valid[LAT-1];
    assign out_id    = stage_id[LAT-1];
    assign out_data  = enc_data_out;
    assign out_chk   = enc_chkbits_out;
    assign enc_reset = ~ecc_reset_n;

    // The whole encoder path moves together whenever the output slot can drain.
    always_comb begin
        adv         = ~out_valid | out_ready;
        fire        = adv & gnt_valid;
        enc_clken   = adv;
        req0_ready  = fire & (gnt_id == REQ0);
        req1_ready  = fire & (gnt_id == REQ1);
        enc_data_in = '0;
        if (gnt_valid) begin
            enc_data_in = (gnt_id == REQ1) ? req1_data : req0_data;
        end
    end

    // Shadow pipeline mirrors the encoder stages; bubbles carry id 0.
    always_ff @(posedge ecc_clk or negedge ecc_reset_n) begin
        if (!ecc_reset_n) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                stage_valid[k] <= 1'b0;
                stage_id[k]    <= REQ0;
            end
        end else if (adv) begin
            stage_valid[0] <= fire;
            stage_id[0]    <= fire ? gnt_id : REQ0;
            for (int unsigned k = 1; k < LAT; k++) begin
                stage_valid[k] <= stage_valid[k-1];
                stage_id[k]    <= stage_id[k-1];
            end
        end
    end

    // Count downstream handshakes, wrapping naturally at 16 bits.
    always_ff @(posedge ecc_clk or negedge ecc_reset_n) begin
        if (!ecc_reset_n) begin
            word_cnt <= '0;
        end else if (out_valid && out_ready) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ecc_enc_arb.sv
// Self-checking bench for ecc_enc_arb with a behavioural two-stage Hamming
// encoder standing in for the external encoder.
module tb_ecc_enc_arb;

    localparam logic [63:0] D0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] D1 = 64'hFEDCBA9876543210;

    logic        ecc_clk = 1'b0;
    logic        ecc_reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [63:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        enc_reset, enc_clken;
    logic [63:0] enc_data_in, enc_data_out;
    logic [7:0]  enc_chkbits_out;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] out_data;
    logic [7:0]  out_chk;
    logic        out_id;
    logic [15:0] word_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 ecc_clk = ~ecc_clk;

    ecc_enc_arb #(.DATA_W(64), .CHK_W(8), .LAT(2)) dut (
        .ecc_clk(ecc_clk), .ecc_reset_n(ecc_reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .enc_reset(enc_reset), .enc_clken(enc_clken), .enc_data_in(enc_data_in),
        .enc_data_out(enc_data_out), .enc_chkbits_out(enc_chkbits_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chk(out_chk), .out_id(out_id), .word_cnt(word_cnt)
    );

    // Hamming SECDED(72,64): data bits occupy non-power-of-two positions.
    function automatic logic [7:0] chk_fn(input logic [63:0] d);
        logic [7:0] c;
        int pos;
        c = '0;
        pos = 2;
        for (int k = 0; k < 64; k++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            for (int j = 0; j < 7; j++) if (pos[j]) c[j] = c[j] ^ d[k];
        end
        c[7] = (^d) ^ (^c[6:0]);
        return c;
    endfunction

    // External encoder model: input register then output register.
    logic [63:0] e_in_q, e_out_q;
    logic [7:0]  e_chk_q;
    always @(posedge ecc_clk or posedge enc_reset) begin
        if (enc_reset) begin
            e_in_q  <= '0;
            e_out_q <= '0;
            e_chk_q <= '0;
        end else if (enc_clken) begin
            e_in_q  <= enc_data_in;
            e_out_q <= e_in_q;
            e_chk_q <= chk_fn(e_in_q);
        end
    end
    assign enc_data_out    = e_out_q;
    assign enc_chkbits_out = e_chk_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: per-requester order queues, check bits against the model.
    always @(negedge ecc_clk) begin
        if (ecc_reset_n) begin
            if (req0_valid && req0_ready) q0.push_back(req0_data);
            if (req1_valid && req1_ready) q1.push_back(req1_data);
            if (out_valid && out_ready) begin
                if ((out_id == 1'b0 && q0.size() == 0) || (out_id == 1'b1 && q1.size() == 0)) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got word %h id %0d expected none", out_data, out_id);
                end else begin
                    chk("sb_data", out_data, (out_id == 1'b0) ? q0.pop_front() : q1.pop_front());
                end
                chk("sb_chk", {56'd0, out_chk}, {56'd0, chk_fn(out_data)});
            end
        end
    end

    typedef struct {
        logic v0, v1, ordy;
        logic e_r0, e_r1, e_ck, e_ov, e_oid;
        logic [1:0] e_sel;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mkv(input logic v0, v1, ordy, r0, r1, ck, ov, oid,
                                 input logic [1:0] sel, input logic [15:0] cnt);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.ordy = ordy;
        v.e_r0 = r0; v.e_r1 = r1; v.e_ck = ck; v.e_ov = ov; v.e_oid = oid;
        v.e_sel = sel; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic do_reset();
        ecc_reset_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge ecc_clk);
        @(negedge ecc_clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_id", {63'd0, out_id}, 64'd0);
        chk("rst_word_cnt", {48'd0, word_cnt}, 64'd0);
        chk("rst_enc_reset", {63'd0, enc_reset}, 64'd1);
        ecc_reset_n = 1'b1;
        @(posedge ecc_clk);
        #1;
    endtask

    task automatic tick();
        @(posedge ecc_clk);
        #1;
    endtask

    logic [63:0] sel_data;
    logic [63:0] hold_data;
    logic [7:0]  hold_chk;
    logic        hold_id;
    logic        found;

    initial begin
        vecs[0]  = mkv(1, 1, 1, 1, 0, 1, 0, 0, 2'd1, 16'd0);
        vecs[1]  = mkv(1, 1, 1, 0, 1, 1, 0, 0, 2'd2, 16'd0);
        vecs[2]  = mkv(1, 1, 1, 1, 0, 1, 1, 0, 2'd1, 16'd0);
        vecs[3]  = mkv(0, 0, 0, 0, 0, 0, 1, 1, 2'd0, 16'd1);
        vecs[4]  = mkv(1, 1, 0, 0, 0, 0, 1, 1, 2'd2, 16'd1);
        vecs[5]  = mkv(0, 1, 1, 0, 1, 1, 1, 1, 2'd2, 16'd1);
        vecs[6]  = mkv(0, 0, 1, 0, 0, 1, 1, 0, 2'd0, 16'd2);
        vecs[7]  = mkv(1, 0, 1, 1, 0, 1, 1, 1, 2'd1, 16'd3);
        vecs[8]  = mkv(0, 0, 1, 0, 0, 1, 0, 0, 2'd0, 16'd4);
        vecs[9]  = mkv(1, 1, 0, 0, 0, 0, 1, 0, 2'd2, 16'd4);
        vecs[10] = mkv(0, 0, 1, 0, 0, 1, 1, 0, 2'd0, 16'd4);
        vecs[11] = mkv(0, 0, 1, 0, 0, 1, 0, 0, 2'd0, 16'd5);

        // Table: arbitration, stall and bubble behaviour cycle by cycle.
        do_reset();
        req0_data = D0;
        req1_data = D1;
        for (int i = 0; i < 12; i++) begin
            req0_valid = vecs[i].v0;
            req1_valid = vecs[i].v1;
            out_ready  = vecs[i].ordy;
            @(negedge ecc_clk);
            sel_data = (vecs[i].e_sel == 2'd1) ? D0 : (vecs[i].e_sel == 2'd2) ? D1 : 64'd0;
            chk($sformatf("v%0d_r0", i), {63'd0, req0_ready}, {63'd0, vecs[i].e_r0});
            chk($sformatf("v%0d_r1", i), {63'd0, req1_ready}, {63'd0, vecs[i].e_r1});
            chk($sformatf("v%0d_clken", i), {63'd0, enc_clken}, {63'd0, vecs[i].e_ck});
            chk($sformatf("v%0d_ov", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            chk($sformatf("v%0d_oid", i), {63'd0, out_id}, {63'd0, vecs[i].e_oid});
            chk($sformatf("v%0d_enc_in", i), enc_data_in, sel_data);
            chk($sformatf("v%0d_cnt", i), {48'd0, word_cnt}, {48'd0, vecs[i].e_cnt});
            tick();
        end

        // Single requester streaming: two-cycle latency, one word per cycle.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = D0;
        out_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge ecc_clk);
            chk("solo_r0", {63'd0, req0_ready}, 64'd1);
            chk("solo_ov", {63'd0, out_valid}, (i >= 2) ? 64'd1 : 64'd0);
            if (i >= 2) begin
                chk("solo_id", {63'd0, out_id}, 64'd0);
                chk("solo_data", out_data, D0);
            end
            chk("solo_cnt", {48'd0, word_cnt}, (i >= 2) ? 64'(i - 2) : 64'd0);
            tick();
        end

        // Both requesters continuously: strict alternation starting with req0.
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_data = {$urandom, $urandom};
            req1_data = {$urandom, $urandom};
            @(negedge ecc_clk);
            chk("alt_r0", {63'd0, req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("alt_r1", {63'd0, req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
            if (i >= 2) chk("alt_oid", {63'd0, out_id}, 64'(i % 2));
            tick();
        end

        // Reset with words in flight: outputs clear at once, nothing stale after.
        @(negedge ecc_clk);
        #2;
        ecc_reset_n = 1'b0;
        #1;
        chk("mid_rst_ov", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_enc_reset", {63'd0, enc_reset}, 64'd1);
        chk("mid_rst_cnt", {48'd0, word_cnt}, 64'd0);
        q0.delete();
        q1.delete();
        @(negedge ecc_clk);
        ecc_reset_n = 1'b1;
        req0_data = {$urandom, $urandom};
        req1_data = {$urandom, $urandom};
        #1;
        chk("post_rst_r0", {63'd0, req0_ready}, 64'd1);
        chk("post_rst_r1", {63'd0, req1_ready}, 64'd0);
        tick();
        @(negedge ecc_clk);
        chk("post_rst_ov0", {63'd0, out_valid}, 64'd0);
        tick();
        @(negedge ecc_clk);
        chk("post_rst_ov1", {63'd0, out_valid}, 64'd1);
        chk("post_rst_id", {63'd0, out_id}, 64'd0);
        tick();

        // Backpressure: five stalled cycles hold everything, then resume.
        for (int i = 0; i < 4; i++) begin
            req0_data = {$urandom, $urandom};
            req1_data = {$urandom, $urandom};
            tick();
        end
        out_ready = 1'b0;
        @(negedge ecc_clk);
        chk("stall_ov", {63'd0, out_valid}, 64'd1);
        hold_data = out_data;
        hold_chk  = out_chk;
        hold_id   = out_id;
        for (int i = 0; i < 5; i++) begin
            @(negedge ecc_clk);
            chk("stall_clken", {63'd0, enc_clken}, 64'd0);
            chk("stall_r0", {63'd0, req0_ready}, 64'd0);
            chk("stall_r1", {63'd0, req1_ready}, 64'd0);
            chk("stall_data", out_data, hold_data);
            chk("stall_chk", {56'd0, out_chk}, {56'd0, hold_chk});
            chk("stall_id", {63'd0, out_id}, {63'd0, hold_id});
            tick();
            req0_data = {$urandom, $urandom};
            req1_data = {$urandom, $urandom};
        end
        out_ready = 1'b1;
        repeat (4) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) tick();
        chk("stall_drain_q0", 64'(q0.size()), 64'd0);
        chk("stall_drain_q1", 64'(q1.size()), 64'd0);

        // Random traffic and backpressure against the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            req0_valid = 1'($urandom % 2);
            req1_valid = 1'($urandom % 2);
            req0_data  = {$urandom, $urandom};
            req1_data  = {$urandom, $urandom};
            out_ready  = ($urandom % 4) != 0;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        repeat (6) tick();
        chk("rand_drain_q0", 64'(q0.size()), 64'd0);
        chk("rand_drain_q1", 64'(q1.size()), 64'd0);

        // Word counter wrap after 65535 deliveries.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = D1;
        out_ready  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 70000 && !found; i++) begin
            @(negedge ecc_clk);
            if (word_cnt == 16'hFFFF) found = 1'b1;
            else tick();
        end
        chk("wrap_reach", {63'd0, found}, 64'd1);
        if (found) begin
            chk("wrap_handshake", {63'd0, out_valid & out_ready}, 64'd1);
            tick();
            chk("wrap_zero", {48'd0, word_cnt}, 64'd0);
        end
        req0_valid = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
